multi_dataflow_mdc_engine: RTL and testbench

Parametrised engine for MDC-based HWPE accelerators. Sits between the streamer and the kernel adapter and gates N_IN input streams and N_OUT output streams. Counts output handshakes per channel against programmable limits and repeats the job for a programmable number of iterations. Reports per-channel counts, iteration progress, done and ready to the control FSM.

---
 rtl/multi_dataflow_mdc_engine_pkg.sv | 31 +++
 rtl/multi_dataflow_mdc_engine_out_counter.sv | 63 ++++++
 rtl/multi_dataflow_mdc_engine.sv | 128 ++++++++++++
 tb/tb_multi_dataflow_mdc_engine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_dataflow_mdc_engine_pkg.sv
// Shared types and constants for the MDC dataflow engine: FSM states and
// the control/flag bundles exchanged with the HWPE control FSM.
package multi_dataflow_mdc_engine_package;

   localparam int unsigned MDC_ENGINE_MAX_CH  = 8;
   localparam int unsigned MDC_ENGINE_CNT_LEN = 1024;
   localparam int unsigned MDC_ENGINE_CW      = $clog2(MDC_ENGINE_CNT_LEN) + 1;
   localparam int unsigned MDC_ENGINE_ITER_W  = 16;

   typedef enum logic [1:0] {
      MDC_IDLE = 2'd0,
      MDC_RUN  = 2'd1,
      MDC_DONE = 2'd2
   } mdc_state_e;

   typedef struct packed {
      logic                                                 clear;
      logic                                                 enable;
      logic                                                 start;
      logic [MDC_ENGINE_ITER_W-1:0]                         nb_iter;
      logic [MDC_ENGINE_MAX_CH-1:0][MDC_ENGINE_CW-1:0]      cnt_limit;
   } ctrl_engine_mdc_t;

   typedef struct packed {
      logic [MDC_ENGINE_MAX_CH-1:0][MDC_ENGINE_CW-1:0]      cnt;
      logic [MDC_ENGINE_ITER_W-1:0]                         iter;
      logic                                                 done;
      logic                                                 ready;
   } flags_engine_mdc_t;

endpackage

// File: rtl/multi_dataflow_mdc_engine_out_counter.sv
// One output channel: latched beat limit, saturating handshake counter and
// the stream gate that closes the channel once its limit is reached.
module mdc_engine_out_counter #(
   parameter  int unsigned CNT_LEN = 1024,
   localparam int unsigned CW      = $clog2(CNT_LEN) + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          load_i,
   input  logic          restart_i,
   input  logic          run_i,
   input  logic [CW-1:0] limit_i,
   input  logic          k_valid_i,
   input  logic          out_ready_i,
   output logic          out_valid_o,
   output logic          k_ready_o,
   output logic [CW-1:0] cnt_o,
   output logic          complete_nxt_o
);

   logic [CW-1:0] cnt_q, cnt_d, lim_q, lim_d, cnt_inc, lim_clip;
   logic          complete, open, hs;

   assign lim_clip = (limit_i > CW'(CNT_LEN)) ? CW'(CNT_LEN) : limit_i;
   assign complete = (cnt_q == lim_q);
   assign open     = run_i & ~complete;
   assign hs       = k_valid_i & out_ready_i & open;
   // cnt never exceeds lim: a handshake is only possible while cnt < lim
   assign cnt_inc  = cnt_q + {{(CW-1){1'b0}}, hs};

   assign out_valid_o    = k_valid_i & open;
   assign k_ready_o      = out_ready_i & open;
   assign cnt_o          = cnt_q;
   assign complete_nxt_o = (cnt_inc == lim_q);

   always_comb begin
      cnt_d = cnt_q;
      lim_d = lim_q;
      if (clear_i) begin
         cnt_d = '0;
         lim_d = '0;
      end else if (load_i) begin
         cnt_d = '0;
         lim_d = lim_clip;
      end else if (restart_i) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_inc;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         lim_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         lim_q <= lim_d;
      end
   end

endmodule

// File: rtl/multi_dataflow_mdc_engine.sv
// Stream gate between streamer and MDC kernel adapter: counts output beats
// per channel against programmable limits and repeats for nb_iter iterations.
module multi_dataflow_mdc_engine
   import multi_dataflow_mdc_engine_package::*;
#(
   parameter  int unsigned N_IN       = 2,
   parameter  int unsigned N_OUT      = 1,
   parameter  int unsigned DATA_WIDTH = 32,
   parameter  int unsigned CNT_LEN    = MDC_ENGINE_CNT_LEN,
   parameter  int unsigned ITER_W     = 16,
   localparam int unsigned CW         = $clog2(CNT_LEN) + 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 clear_i,
   input  logic                                 enable_i,
   input  logic                                 start_i,
   input  logic [ITER_W-1:0]                    nb_iter_i,
   input  logic [N_OUT-1:0][CW-1:0]             cnt_limit_i,
   input  logic [N_IN-1:0][DATA_WIDTH-1:0]      in_data_i,
   input  logic [N_IN-1:0]                      in_valid_i,
   output logic [N_IN-1:0]                      in_ready_o,
   output logic [N_IN-1:0][DATA_WIDTH-1:0]      k_in_data_o,
   output logic [N_IN-1:0]                      k_in_valid_o,
   input  logic [N_IN-1:0]                      k_in_ready_i,
   input  logic [N_OUT-1:0][DATA_WIDTH-1:0]     k_out_data_i,
   input  logic [N_OUT-1:0]                     k_out_valid_i,
   output logic [N_OUT-1:0]                     k_out_ready_o,
   output logic [N_OUT-1:0][DATA_WIDTH-1:0]     out_data_o,
   output logic [N_OUT-1:0]                     out_valid_o,
   input  logic [N_OUT-1:0]                     out_ready_i,
   output logic [N_OUT-1:0][CW-1:0]             cnt_o,
   output logic [ITER_W-1:0]                    iter_o,
   output logic                                 done_o,
   output logic                                 ready_o
);

   mdc_state_e          state_q, state_d;
   logic [ITER_W-1:0]   iter_q, iter_d, nb_iter_q, nb_iter_d;
   logic [ITER_W:0]     iter_inc;
   logic [N_OUT-1:0]    comp_nxt;
   logic                run, load, all_done, last_iter, iter_end, job_end;

   // Completion looks ahead through this cycle's handshake, so the iteration
   // closes on the edge that accepts the last beat.
   assign all_done  = &comp_nxt;
   assign iter_inc  = {1'b0, iter_q} + {{ITER_W{1'b0}}, 1'b1};
   assign last_iter = (iter_inc >= {1'b0, nb_iter_q});
   assign iter_end  = run & all_done & ~last_iter;
   assign job_end   = run & all_done & last_iter;
   assign load      = (state_q == MDC_IDLE) & start_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= MDC_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = MDC_IDLE;
      end else begin
         unique case (state_q)
            MDC_IDLE: if (start_i) state_d = MDC_RUN;
            MDC_RUN:  if (job_end) state_d = MDC_DONE;
            MDC_DONE: state_d = MDC_IDLE;
            default:  state_d = MDC_IDLE;
         endcase
      end
   end

   always_comb begin
      ready_o = (state_q == MDC_IDLE);
      done_o  = (state_q == MDC_DONE);
      run     = (state_q == MDC_RUN) & enable_i;
   end

   always_comb begin
      iter_d    = iter_q;
      nb_iter_d = nb_iter_q;
      if (clear_i) begin
         iter_d    = '0;
         nb_iter_d = '0;
      end else if (load) begin
         iter_d    = '0;
         nb_iter_d = (nb_iter_i == '0) ? ITER_W'(1) : nb_iter_i;
      end else if (run && all_done) begin
         iter_d    = iter_inc[ITER_W-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         iter_q    <= '0;
         nb_iter_q <= '0;
      end else begin
         iter_q    <= iter_d;
         nb_iter_q <= nb_iter_d;
      end
   end

   assign iter_o       = iter_q;
   assign k_in_data_o  = in_data_i;
   assign k_in_valid_o = in_valid_i & {N_IN{run}};
   assign in_ready_o   = k_in_ready_i & {N_IN{run}};
   assign out_data_o   = k_out_data_i;

   for (genvar c = 0; c < N_OUT; c++) begin : g_out
      mdc_engine_out_counter #(
         .CNT_LEN (CNT_LEN)
      ) u_cnt (
         .clk_i          (clk_i),
         .rst_ni         (rst_ni),
         .clear_i        (clear_i),
         .load_i         (load),
         .restart_i      (iter_end),
         .run_i          (run),
         .limit_i        (cnt_limit_i[c]),
         .k_valid_i      (k_out_valid_i[c]),
         .out_ready_i    (out_ready_i[c]),
         .out_valid_o    (out_valid_o[c]),
         .k_ready_o      (k_out_ready_o[c]),
         .cnt_o          (cnt_o[c]),
         .complete_nxt_o (comp_nxt[c])
      );
   end

endmodule

// File: tb/tb_multi_dataflow_mdc_engine.sv
// Randomised bench for the MDC engine with a transaction-level job model:
// per-channel beat budgets, iteration count and the done pulse.
module tb_multi_dataflow_mdc_engine;

   localparam int N_IN = 2;
   localparam int N_OUT = 2;
   localparam int DW = 32;
   localparam int CNT_LEN = 1024;
   localparam int ITER_W = 16;
   localparam int CW = $clog2(CNT_LEN) + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear_i = 0, enable_i = 0, start_i = 0;
   logic [ITER_W-1:0] nb_iter_i = '0;
   logic [N_OUT-1:0][CW-1:0] cnt_limit_i = '0;
   logic [N_IN-1:0][DW-1:0] in_data_i = '0;
   logic [N_IN-1:0] in_valid_i = '0, in_ready_o, k_in_valid_o;
   logic [N_IN-1:0] k_in_ready_i = '0;
   logic [N_IN-1:0][DW-1:0] k_in_data_o;
   logic [N_OUT-1:0][DW-1:0] k_out_data_i = '0, out_data_o;
   logic [N_OUT-1:0] k_out_valid_i = '0, k_out_ready_o, out_valid_o;
   logic [N_OUT-1:0] out_ready_i = '0;
   logic [N_OUT-1:0][CW-1:0] cnt_o;
   logic [ITER_W-1:0] iter_o;
   logic done_o, ready_o;

   always #5 clk = ~clk;

   multi_dataflow_mdc_engine #(
      .N_IN(N_IN), .N_OUT(N_OUT), .DATA_WIDTH(DW), .CNT_LEN(CNT_LEN), .ITER_W(ITER_W)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .enable_i(enable_i),
      .start_i(start_i), .nb_iter_i(nb_iter_i), .cnt_limit_i(cnt_limit_i),
      .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .k_in_data_o(k_in_data_o), .k_in_valid_o(k_in_valid_o), .k_in_ready_i(k_in_ready_i),
      .k_out_data_i(k_out_data_i), .k_out_valid_i(k_out_valid_i), .k_out_ready_o(k_out_ready_o),
      .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .cnt_o(cnt_o), .iter_o(iter_o), .done_o(done_o), .ready_o(ready_o)
   );

   int n_tests = 0, n_fail = 0;

   // Job model: beats granted per channel this iteration, iterations done.
   bit m_busy, m_done;
   int m_beats[N_OUT], m_lim[N_OUT], m_iter, m_nb;
   int exp_hs[N_OUT], obs_hs[N_OUT], obs_done;
   logic [DW-1:0] exp_q0[$], obs_q0[$];

   task automatic m_reset();
      m_busy = 0; m_done = 0; m_iter = 0; m_nb = 0;
      for (int c = 0; c < N_OUT; c++) begin m_beats[c] = 0; m_lim[c] = 0; end
   endtask

   task automatic clr_obs();
      for (int c = 0; c < N_OUT; c++) begin exp_hs[c] = 0; obs_hs[c] = 0; end
      obs_done = 0; exp_q0.delete(); obs_q0.delete();
   endtask

   // Advance one clock; records what the DUT did and what the job rules allow.
   task automatic tick();
      bit all_c;
      #1;
      for (int c = 0; c < N_OUT; c++)
         if (out_valid_o[c] && out_ready_i[c]) begin
            obs_hs[c]++;
            if (c == 0) obs_q0.push_back(out_data_o[0]);
         end
      if (done_o) obs_done++;
      if (clear_i) begin
         m_reset();
      end else if (m_done) begin
         m_done = 0;
      end else if (!m_busy) begin
         if (start_i) begin
            m_busy = 1; m_iter = 0;
            m_nb = (nb_iter_i == 0) ? 1 : int'(nb_iter_i);
            for (int c = 0; c < N_OUT; c++) begin
               m_beats[c] = 0;
               m_lim[c] = (int'(cnt_limit_i[c]) > CNT_LEN) ? CNT_LEN : int'(cnt_limit_i[c]);
            end
         end
      end else if (enable_i) begin
         for (int c = 0; c < N_OUT; c++)
            if (m_beats[c] < m_lim[c] && k_out_valid_i[c] && out_ready_i[c]) begin
               m_beats[c]++; exp_hs[c]++;
               if (c == 0) exp_q0.push_back(k_out_data_i[0]);
            end
         all_c = 1;
         for (int c = 0; c < N_OUT; c++) if (m_beats[c] != m_lim[c]) all_c = 0;
         if (all_c) begin
            m_iter++;
            if (m_iter >= m_nb) begin m_busy = 0; m_done = 1; end
            else for (int c = 0; c < N_OUT; c++) m_beats[c] = 0;
         end
      end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic start_job(input int l0, input int l1, input int nb);
      cnt_limit_i[0] = CW'(l0); cnt_limit_i[1] = CW'(l1);
      nb_iter_i = ITER_W'(nb); start_i = 1;
      tick();
      start_i = 0;
   endtask

   task automatic test_reset();
      in_valid_i = '1; k_in_ready_i = '1; k_out_valid_i = '1; out_ready_i = '1; enable_i = 1;
      repeat (2) @(negedge clk);
      #1;
      n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready_o); end
      n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done_o); end
      n_tests++; if (cnt_o !== '0 || iter_o !== '0) begin n_fail++; $display("FAIL reset_cnt got %h/%h exp 0", cnt_o, iter_o); end
      n_tests++; if (out_valid_o !== '0 || k_out_ready_o !== '0 || k_in_valid_o !== '0 || in_ready_o !== '0) begin
         n_fail++; $display("FAIL reset_gates got %b%b%b%b exp 0", out_valid_o, k_out_ready_o, k_in_valid_o, in_ready_o); end
      rst_n = 1; m_reset();
      @(negedge clk);
   endtask

   task automatic test_single_iter();
      int cyc = 0;
      clr_obs(); k_out_valid_i = '1; out_ready_i = '1; enable_i = 1;
      start_job(16, 0, 1);
      while ((m_busy || m_done) && cyc < 100) begin
         k_out_data_i[0] = $urandom;
         tick(); cyc++;
         n_tests++; if (done_o !== m_done) begin n_fail++; $display("FAIL single_done cyc %0d got %b exp %b", cyc, done_o, m_done); end
         n_tests++; if (cnt_o[0] !== CW'(m_beats[0])) begin n_fail++; $display("FAIL single_cnt got %0d exp %0d", cnt_o[0], m_beats[0]); end
      end
      n_tests++; if (cyc >= 100) begin n_fail++; $display("FAIL single_timeout got %0d cycles", cyc); end
      n_tests++; if (obs_hs[0] !== 16 || cnt_o[0] !== CW'(16)) begin n_fail++; $display("FAIL single_beats got %0d/%0d exp 16", obs_hs[0], cnt_o[0]); end
      n_tests++; if (obs_done !== 1 || iter_o !== ITER_W'(1)) begin n_fail++; $display("FAIL single_iter done %0d iter %0d exp 1/1", obs_done, iter_o); end
      n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b exp 1", ready_o); end
   endtask

   task automatic test_multi_iter();
      int cyc = 0;
      clr_obs(); k_out_valid_i = '1; out_ready_i = '1; enable_i = 1;
      start_job(4, 8, 3);
      while ((m_busy || m_done) && cyc < 200) begin
         #1;
         for (int c = 0; c < N_OUT; c++) begin
            n_tests++;
            if (out_valid_o[c] !== (m_busy && m_beats[c] < m_lim[c])) begin
               n_fail++; $display("FAIL multi_gate ch%0d got %b", c, out_valid_o[c]); end
         end
         tick(); cyc++;
         n_tests++; if (iter_o !== ITER_W'(m_iter)) begin n_fail++; $display("FAIL multi_iter got %0d exp %0d", iter_o, m_iter); end
         n_tests++; if (cnt_o[1] !== CW'(m_beats[1])) begin n_fail++; $display("FAIL multi_cnt1 got %0d exp %0d", cnt_o[1], m_beats[1]); end
         n_tests++; if (done_o !== m_done) begin n_fail++; $display("FAIL multi_done got %b exp %b", done_o, m_done); end
      end
      n_tests++; if (cyc >= 200) begin n_fail++; $display("FAIL multi_timeout got %0d cycles", cyc); end
      n_tests++; if (obs_hs[0] !== 12 || obs_hs[1] !== 24) begin n_fail++; $display("FAIL multi_totals got %0d/%0d exp 12/24", obs_hs[0], obs_hs[1]); end
      n_tests++; if (obs_done !== 1 || iter_o !== ITER_W'(3)) begin n_fail++; $display("FAIL multi_end done %0d iter %0d exp 1/3", obs_done, iter_o); end
   endtask

   task automatic test_backpressure();
      int cyc = 0;
      logic [CW-1:0] frozen = '0;
      logic [N_IN-1:0] exp_kv, exp_ir;
      clr_obs(); enable_i = 1;
      start_job(100, 0, 1);
      while ((m_busy || m_done) && cyc < 2000) begin
         enable_i = !(cyc >= 20 && cyc < 30);
         k_out_valid_i = N_OUT'($urandom); out_ready_i = N_OUT'($urandom);
         k_out_data_i[0] = $urandom; k_out_data_i[1] = $urandom;
         in_valid_i = N_IN'($urandom); k_in_ready_i = N_IN'($urandom); in_data_i[0] = $urandom;
         #1;
         exp_kv = (m_busy && enable_i) ? in_valid_i : '0;
         exp_ir = (m_busy && enable_i) ? k_in_ready_i : '0;
         n_tests++; if (k_in_valid_o !== exp_kv || in_ready_o !== exp_ir || k_in_data_o[0] !== in_data_i[0]) begin
            n_fail++; $display("FAIL bp_inpath got %b/%b exp %b/%b", k_in_valid_o, in_ready_o, exp_kv, exp_ir); end
         n_tests++;
         if (out_valid_o[0] !== (k_out_valid_i[0] && m_busy && enable_i && m_beats[0] < m_lim[0])) begin
            n_fail++; $display("FAIL bp_valid got %b", out_valid_o[0]); end
         if (cyc == 20) frozen = cnt_o[0];
         tick(); cyc++;
         if (cyc > 20 && cyc <= 30) begin
            n_tests++; if (cnt_o[0] !== frozen) begin n_fail++; $display("FAIL bp_freeze got %0d exp %0d", cnt_o[0], frozen); end
         end
         n_tests++; if (cnt_o[0] !== CW'(m_beats[0])) begin n_fail++; $display("FAIL bp_cnt got %0d exp %0d", cnt_o[0], m_beats[0]); end
      end
      enable_i = 1;
      n_tests++; if (cyc >= 2000) begin n_fail++; $display("FAIL bp_timeout got %0d cycles", cyc); end
      n_tests++; if (obs_hs[0] !== 100 || exp_hs[0] !== 100) begin n_fail++; $display("FAIL bp_count got %0d exp 100", obs_hs[0]); end
      n_tests++; if (obs_q0 != exp_q0) begin n_fail++; $display("FAIL bp_data got %0d beats exp %0d, contents differ", obs_q0.size(), exp_q0.size()); end
   endtask

   task automatic test_clear_final();
      int cyc = 0;
      clr_obs(); k_out_valid_i = '1; out_ready_i = '1; enable_i = 1;
      start_job(3, 0, 1);
      while (m_beats[0] < 2 && cyc < 20) begin tick(); cyc++; end
      clear_i = 1;
      tick();
      clear_i = 0;
      n_tests++; if (done_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL clr_state done %b ready %b exp 0/1", done_o, ready_o); end
      n_tests++; if (cnt_o !== '0 || iter_o !== '0) begin n_fail++; $display("FAIL clr_cnt got %h/%0d exp 0", cnt_o, iter_o); end
      tick();
      n_tests++; if (done_o !== 1'b0 || obs_done !== 0) begin n_fail++; $display("FAIL clr_nodone got %b/%0d exp 0", done_o, obs_done); end
   endtask

   task automatic test_zero_limits();
      clr_obs(); k_out_valid_i = '1; out_ready_i = '1; enable_i = 1;
      start_job(0, 0, 0);
      #1;
      n_tests++; if (done_o !== 1'b0 || ready_o !== 1'b0 || out_valid_o !== '0) begin
         n_fail++; $display("FAIL zero_run done %b ready %b valid %b exp 0/0/0", done_o, ready_o, out_valid_o); end
      tick();
      n_tests++; if (done_o !== 1'b1 || iter_o !== ITER_W'(1)) begin n_fail++; $display("FAIL zero_done got %b iter %0d exp 1/1", done_o, iter_o); end
      tick();
      n_tests++; if (ready_o !== 1'b1 || done_o !== 1'b0 || obs_hs[0] !== 0 || obs_hs[1] !== 0) begin
         n_fail++; $display("FAIL zero_end ready %b done %b hs %0d", ready_o, done_o, obs_hs[0] + obs_hs[1]); end
   endtask

   task automatic test_start_in_run();
      int cyc = 0;
      clr_obs(); k_out_valid_i = '1; enable_i = 1; out_ready_i = '1;
      start_job(10, 0, 1);
      while ((m_busy || m_done) && cyc < 100) begin
         out_ready_i = N_OUT'($urandom);
         start_i = (cyc == 3);
         if (cyc == 3) begin nb_iter_i = 5; cnt_limit_i[0] = 2; cnt_limit_i[1] = 2; end
         tick(); cyc++;
         n_tests++; if (cnt_o[0] !== CW'(m_beats[0])) begin n_fail++; $display("FAIL sir_cnt got %0d exp %0d", cnt_o[0], m_beats[0]); end
      end
      start_i = 0;
      n_tests++; if (cyc >= 100) begin n_fail++; $display("FAIL sir_timeout got %0d cycles", cyc); end
      n_tests++; if (obs_hs[0] !== 10 || iter_o !== ITER_W'(1) || obs_done !== 1) begin
         n_fail++; $display("FAIL sir_result hs %0d iter %0d done %0d exp 10/1/1", obs_hs[0], iter_o, obs_done); end
   endtask

   task automatic test_async_reset();
      clr_obs(); k_out_valid_i = '1; out_ready_i = '1; enable_i = 1;
      in_valid_i = '1; k_in_ready_i = '1;
      start_job(50, 7, 2);
      repeat (5) tick();
      #2 rst_n = 0;
      #1;
      n_tests++; if (ready_o !== 1'b1 || done_o !== 1'b0 || cnt_o !== '0 || iter_o !== '0) begin
         n_fail++; $display("FAIL arst_flags ready %b done %b cnt %h iter %0d", ready_o, done_o, cnt_o, iter_o); end
      n_tests++; if (out_valid_o !== '0 || k_out_ready_o !== '0 || k_in_valid_o !== '0 || in_ready_o !== '0) begin
         n_fail++; $display("FAIL arst_gates got %b%b%b%b exp 0", out_valid_o, k_out_ready_o, k_in_valid_o, in_ready_o); end
      @(negedge clk);
      rst_n = 1; m_reset();
      @(negedge clk);
   endtask

   initial begin
      m_reset(); clr_obs();
      test_reset();
      test_single_iter();
      test_multi_iter();
      test_backpressure();
      test_clear_final();
      test_zero_limits();
      test_start_in_run();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
